dmem: RTL and testbench
=======================

DMEM -- requirements
Module: dmem

Interface
REQ-001 SHALL provide parameter DATA_W, default 16: data word width in bits, a multiple of 8.
REQ-002 SHALL provide parameter ADDR_W, default 16: address port width.
REQ-003 SHALL provide parameter DEPTH, default 256: number of words, at most 2^ADDR_W.
REQ-004 SHALL provide parameter WRITE_FIRST, default 1: same-address load/store collision policy (1 = return new data, 0 = return old data).
REQ-005 SHALL provide port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL provide port rst_n, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL provide port address, input, ADDR_W: word address, where one address selects one DATA_W word.
REQ-008 SHALL provide port data_in, input, DATA_W: store data.
REQ-009 SHALL provide port byte_en, input, DATA_W/8: per-byte store enable; bit i covers data bits [8i+7:8i].
REQ-010 SHALL provide port store, input, 1: write request.
REQ-011 SHALL provide port load, input, 1: read request.
REQ-012 SHALL provide port ready, output, 1: high when requests are accepted.
REQ-013 SHALL provide port data_out, output, DATA_W: registered read data.
REQ-014 SHALL provide port valid, output, 1: one-cycle pulse marking data_out as fresh.
REQ-015 SHALL provide port err, output, 1: one-cycle pulse flagging an out-of-range access.

Function
REQ-016 SHALL implement a two-state FSM: INIT and IDLE.
REQ-017 INIT SHALL clear one word per cycle using a counter running 0..DEPTH-1, then move to IDLE; INIT lasts exactly DEPTH cycles after rst_n rises.
REQ-018 ready SHALL be 0 in INIT and 1 in IDLE; store or load while ready=0 SHALL be ignored, with no write, no valid and no err.
REQ-019 A store sampled with ready=1 and address<DEPTH SHALL, on that edge, write only the bytes whose byte_en bit is 1; other bytes keep their value.
REQ-020 A load sampled with ready=1 and address<DEPTH SHALL drive data_out with the word at the next edge and pulse valid high for exactly one cycle (latency 1).
REQ-021 Without a load, data_out SHALL hold its last value and valid SHALL be 0.
REQ-022 A simultaneous store and load to the same address SHALL return the byte-merged new word when WRITE_FIRST=1, or the pre-store word when WRITE_FIRST=0; the store SHALL complete in both cases.
REQ-023 A simultaneous store and load to different addresses SHALL both complete in the same cycle.
REQ-024 Any accepted request with address>=DEPTH SHALL perform no write and pulse err for one cycle; if it is a load, it SHALL also set data_out=0 and pulse valid.
REQ-025 Back-to-back loads on consecutive cycles SHALL produce a valid pulse on each following cycle, with no bubbles.

Reset
REQ-026 Asserting rst_n=0 SHALL immediately force data_out=0, valid=0, err=0 and ready=0, set the state to INIT and set the clear counter to 0.
REQ-027 The storage array SHALL NOT be reset asynchronously; its contents SHALL be zeroed only by INIT.
REQ-028 Asserting reset during INIT or IDLE SHALL abort any activity and restart a full DEPTH-cycle INIT after release.

Structure
REQ-029 Package dmem_pkg SHALL hold the FSM state enum and a byte-lane-count constant/function (DATA_W/8).
REQ-030 Storage SHALL be a sub-module dmem_array with one byte-enabled synchronous write port and one synchronous read port; dmem SHALL hold the FSM, the clear counter, range checking, collision muxing and output registers.

Verification
REQ-031 After reset and DEPTH+1 cycles, load at 0x0000 -> ready=1 and data_out=0x0000 with valid=1 one cycle later.
REQ-032 Store 0x8686 at 0x0002 with byte_en=11, then load at 0x0002 -> data_out=0x8686 with valid=1 on the next cycle; a following load at 0x0000 -> 0x0000.
REQ-033 Store 0x1234 at 0x0010 with byte_en=11, store 0xABCD at 0x0010 with byte_en=01, then load -> 0x12CD.
REQ-034 Store 0x5555 at 0x0005; then a simultaneous store of 0xAAAA and a load at 0x0005 -> 0xAAAA (WRITE_FIRST=1) or 0x5555 (WRITE_FIRST=0); a subsequent load -> 0xAAAA in both cases.
REQ-035 With DEPTH=256, store 0xFFFF at 0x0100 -> err pulse and memory unchanged; load at 0x0100 -> err=1, valid=1, data_out=0x0000.
REQ-036 Pulse rst_n low at INIT cycle 100 -> outputs clear immediately; after release ready stays 0 for 256 cycles, and stores issued meanwhile are ignored.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the dmem block: FSM state encoding and byte-lane count.
package dmem_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_e;

    function automatic int unsigned byte_lanes(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Byte-enabled word storage: one synchronous write port, one synchronous read port.
// Contents are never reset; the read register holds its value when no read is requested.
module dmem_array
    import dmem_pkg::*;
#(
    parameter  int DATA_W = 16,
    parameter  int DEPTH  = 256,
    parameter  int IDX_W  = 8,
    localparam int LANES  = byte_lanes(DATA_W)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [LANES-1:0]  wbe,
    input  logic              re,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    // Read samples the pre-write contents, so a same-edge write is not visible here.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < LANES; i++) begin
                if (wbe[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem.sv
// Data memory controller: clear-on-reset sequencing, range checking and load/store collision handling.
//   state   | meaning
//   ST_INIT | clearing one word per cycle, requests ignored (ready=0)
//   ST_IDLE | accepting loads and stores (ready=1)
module dmem
    import dmem_pkg::*;
#(
    parameter  int DATA_W      = 16,
    parameter  int ADDR_W      = 16,
    parameter  int DEPTH       = 256,
    parameter  int WRITE_FIRST = 1,
    localparam int LANES       = byte_lanes(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    input  logic [LANES-1:0]  byte_en,
    input  logic              store,
    input  logic              load,
    output logic              ready,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              err
);

    localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_A  = (ADDR_W+1)'(DEPTH);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic               zero_q, zero_d;
    logic [DATA_W-1:0]  mask_q, mask_d;
    logic [DATA_W-1:0]  wdat_q, wdat_d;

    logic               in_range;
    logic [IDX_W-1:0]   idx;
    logic [DATA_W-1:0]  be_mask;
    logic               arr_we;
    logic [IDX_W-1:0]   arr_waddr;
    logic [DATA_W-1:0]  arr_wdata;
    logic [LANES-1:0]   arr_wbe;
    logic               arr_re;
    logic [DATA_W-1:0]  arr_rdata;

    assign in_range = {1'b0, address} < DEPTH_A;
    assign idx      = address[IDX_W-1:0];
    assign ready    = (state_q == ST_IDLE);

    always_comb begin
        be_mask = '0;
        for (int i = 0; i < LANES; i++) begin
            be_mask[8*i +: 8] = {8{byte_en[i]}};
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        zero_d    = zero_q;
        mask_d    = mask_q;
        wdat_d    = wdat_q;
        arr_we    = 1'b0;
        arr_waddr = idx;
        arr_wdata = data_in;
        arr_wbe   = byte_en;
        arr_re    = 1'b0;
        case (state_q)
            ST_INIT: begin
                arr_we    = 1'b1;
                arr_waddr = cnt_q;
                arr_wdata = '0;
                arr_wbe   = '1;
                cnt_d     = cnt_q + IDX_W'(1);
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            ST_IDLE: begin
                arr_we  = store && in_range;
                arr_re  = load && in_range;
                valid_d = load;
                err_d   = (load || store) && !in_range;
                // A single address port means store+load always collide; write-first
                // overlays the stored bytes on the old word read on the same edge.
                if (load) begin
                    zero_d = !in_range;
                    wdat_d = data_in;
                    mask_d = ((WRITE_FIRST != 0) && store) ? be_mask : '0;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            zero_q  <= 1'b1;
            mask_q  <= '0;
            wdat_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            zero_q  <= zero_d;
            mask_q  <= mask_d;
            wdat_q  <= wdat_d;
        end
    end

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .waddr (arr_waddr),
        .wdata (arr_wdata),
        .wbe   (arr_wbe),
        .re    (arr_re),
        .raddr (idx),
        .rdata (arr_rdata)
    );

    assign data_out = zero_q ? '0 : ((arr_rdata & ~mask_q) | (wdat_q & mask_q));
    assign valid    = valid_q;
    assign err      = err_q;

endmodule

// File: tb/tb_dmem.sv
// Directed bench for dmem: two instances (write-first and read-first) driven in parallel,
// checked against a behavioural memory model through an expected-result queue.
module tb_dmem;

    logic        clk;
    logic        rst_n;
    logic [15:0] address;
    logic [15:0] data_in;
    logic [1:0]  byte_en;
    logic        store;
    logic        load;

    logic        ready_wf, valid_wf, err_wf;
    logic [15:0] data_wf;
    logic        ready_rf, valid_rf, err_rf;
    logic [15:0] data_rf;

    dmem #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .WRITE_FIRST(1)) dut_wf (
        .clk(clk), .rst_n(rst_n), .address(address), .data_in(data_in), .byte_en(byte_en),
        .store(store), .load(load), .ready(ready_wf), .data_out(data_wf), .valid(valid_wf), .err(err_wf)
    );

    dmem #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .WRITE_FIRST(0)) dut_rf (
        .clk(clk), .rst_n(rst_n), .address(address), .data_in(data_in), .byte_en(byte_en),
        .store(store), .load(load), .ready(ready_rf), .data_out(data_rf), .valid(valid_rf), .err(err_rf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [15:0] data_wf;
        logic [15:0] data_rf;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] mem_m [256];
    logic [15:0] out_wf_m, out_rf_m;
    logic        rdy;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] din, input logic [1:0] be);
        logic [15:0] r;
        r = old;
        for (int i = 0; i < 2; i++) begin
            if (be[i]) r[8*i +: 8] = din[8*i +: 8];
        end
        return r;
    endfunction

    task automatic op(input logic st, input logic ld, input logic [15:0] addr,
                      input logic [15:0] din, input logic [1:0] be);
        exp_t        e;
        logic        inr;
        logic [15:0] old, nw;
        check("ready_wf", ready_wf, rdy);
        check("ready_rf", ready_rf, rdy);
        address = addr;
        data_in = din;
        byte_en = be;
        store   = st;
        load    = ld;
        inr     = addr < 16'd256;
        old     = 16'h0;
        nw      = 16'h0;
        if (inr) begin
            old = mem_m[addr[7:0]];
            nw  = merge(old, din, be);
        end
        if (rdy && ld) begin
            out_wf_m = !inr ? 16'h0 : (st ? nw : old);
            out_rf_m = !inr ? 16'h0 : old;
        end
        if (rdy && st && inr) mem_m[addr[7:0]] = nw;
        e.valid   = rdy && ld;
        e.err     = rdy && (ld || st) && !inr;
        e.data_wf = out_wf_m;
        e.data_rf = out_rf_m;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("valid_wf", valid_wf, e.valid);
        check("valid_rf", valid_rf, e.valid);
        check("err_wf", err_wf, e.err);
        check("err_rf", err_rf, e.err);
        check("data_wf", data_wf, e.data_wf);
        check("data_rf", data_rf, e.data_rf);
    endtask

    task automatic idle();
        op(1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    endtask

    task automatic reset_assert();
        rst_n = 1'b0;
        #1;
        check("rst_data_wf", data_wf, 16'h0);
        check("rst_data_rf", data_rf, 16'h0);
        check("rst_valid", {valid_wf, valid_rf}, 2'b00);
        check("rst_err", {err_wf, err_rf}, 2'b00);
        check("rst_ready", {ready_wf, ready_rf}, 2'b00);
        out_wf_m = 16'h0;
        out_rf_m = 16'h0;
        rdy      = 1'b0;
        sb.delete();
        for (int i = 0; i < 256; i++) mem_m[i] = 16'h0;
    endtask

    task automatic reset_release();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic init_run(input int n);
        for (int i = 0; i < n; i++) begin
            if (i >= 10) op(1'b1, 1'b1, 16'h0000, 16'hBEEF, 2'b11);
            else         idle();
        end
    endtask

    initial begin
        rst_n   = 1'b1;
        address = '0;
        data_in = '0;
        byte_en = '0;
        store   = 1'b0;
        load    = 1'b0;
        rdy     = 1'b0;
        #2;
        reset_assert();
        repeat (3) @(posedge clk);
        #1;
        check("hold_rst_ready", ready_wf, 1'b0);
        reset_release();

        init_run(256);
        rdy = 1'b1;

        op(1'b0, 1'b1, 16'h0000, 16'h0, 2'b00);
        check("post_init_load0", data_wf, 16'h0000);

        op(1'b1, 1'b0, 16'h0002, 16'h8686, 2'b11);
        op(1'b0, 1'b1, 16'h0002, 16'h0, 2'b00);
        check("load2", data_wf, 16'h8686);
        op(1'b0, 1'b1, 16'h0000, 16'h0, 2'b00);
        check("load0_b2b", {valid_wf, data_wf}, {1'b1, 16'h0000});

        op(1'b1, 1'b0, 16'h0010, 16'h1234, 2'b11);
        op(1'b1, 1'b0, 16'h0010, 16'hABCD, 2'b01);
        op(1'b0, 1'b1, 16'h0010, 16'h0, 2'b00);
        check("partial_store", data_wf, 16'h12CD);

        op(1'b1, 1'b0, 16'h0005, 16'h5555, 2'b11);
        op(1'b1, 1'b1, 16'h0005, 16'hAAAA, 2'b11);
        check("collide_wf", data_wf, 16'hAAAA);
        check("collide_rf", data_rf, 16'h5555);
        op(1'b0, 1'b1, 16'h0005, 16'h0, 2'b00);
        check("after_collide", {data_wf, data_rf}, {16'hAAAA, 16'hAAAA});
        op(1'b1, 1'b1, 16'h0005, 16'h7777, 2'b10);
        op(1'b0, 1'b1, 16'h0005, 16'h0, 2'b00);

        op(1'b1, 1'b0, 16'h0100, 16'hFFFF, 2'b11);
        op(1'b0, 1'b1, 16'h0100, 16'h0, 2'b00);
        check("oor_load", {err_wf, valid_wf, data_wf}, {1'b1, 1'b1, 16'h0000});
        idle();
        op(1'b0, 1'b1, 16'h0000, 16'h0, 2'b00);
        op(1'b1, 1'b1, 16'hFFFF, 16'h1111, 2'b11);
        op(1'b1, 1'b0, 16'h00FF, 16'hC3A5, 2'b11);
        op(1'b0, 1'b1, 16'h00FF, 16'h0, 2'b00);
        idle();
        idle();

        op(1'b0, 1'b1, 16'h0002, 16'h0, 2'b00);
        reset_assert();
        reset_release();
        init_run(100);
        reset_assert();
        reset_release();
        init_run(256);
        rdy = 1'b1;

        op(1'b0, 1'b1, 16'h0002, 16'h0, 2'b00);
        op(1'b0, 1'b1, 16'h0005, 16'h0, 2'b00);
        op(1'b0, 1'b1, 16'h0000, 16'h0, 2'b00);
        check("cleared_after_reinit", {valid_wf, data_wf}, {1'b1, 16'h0000});
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
